// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Load/store initiator for the MEM stage. It takes one request per handshake
// from the pipeline and drives a byte-addressed, big-endian data memory.
// Halfword accesses are built from two byte beats. Loads are sign- or
// zero-extended. Misaligned, out-of-range and illegal requests are rejected
// without touching memory. Every accepted request returns one response pulse.
//
// Parameters
//   MEM_BYTES      data memory size in bytes, used for the range check
//
// Ports
//   clk            single clock; all state changes on posedge
//   rst            synchronous active-high reset
//   req_valid      request present
//   req_ready      block can accept a request (IDLE and not in reset)
//   req_op         000 LW, 001 SW, 010 LB, 011 SB, 100 LH, 101 SH; 11x illegal
//   req_signed     sign-extend LB/LH results
//   req_addr       byte address
//   req_wdata      store data
//   resp_valid     one-cycle response pulse
//   resp_data      load result; 0 for stores and faults
//   resp_fault     request rejected (qualified by resp_valid)
//   address        memory byte address
//   write_data     memory store data
//   Mem_Write_Read memory command: 10 read, 01 write, 00 idle
//   word_byte      0 word access, 1 byte access
//   Read_data      memory read data (byte reads return the byte in [7:0])

module mem_access_unit #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [1:0]  Mem_Write_Read,
    output logic        word_byte,
    input  logic [31:0] Read_data
);

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SB = 3'b011;
    localparam logic [2:0] OP_LH = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [7:0]  wdata_lo_q;
    logic [7:0]  beat0_byte;

    logic        accept;
    logic        req_fault;
    logic [32:0] access_size;
    logic [32:0] range_end;
    logic [31:0] beat0_wdata;
    logic        half_q;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        return s ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        return s ? {{16{h[15]}}, h} : {16'd0, h};
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign half_q    = (op_q == OP_LH) || (op_q == OP_SH);

    // Fault check on the incoming request. The end address is computed in
    // 33 bits so an address near 2^32 cannot wrap around and pass the check.
    always_comb begin
        access_size = 33'd1;
        req_fault   = 1'b0;
        case (req_op)
            OP_LW, OP_SW: begin
                access_size = 33'd4;
                if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
            end
            OP_LH, OP_SH: begin
                access_size = 33'd2;
                if (req_addr[0]) req_fault = 1'b1;
            end
            OP_LB, OP_SB: access_size = 33'd1;
            default:      req_fault = 1'b1;
        endcase
        range_end = {1'b0, req_addr} + access_size;
        if (range_end > MEM_LIMIT) req_fault = 1'b1;
    end

    // First-beat store data. SH sends its high byte first because the lower
    // address holds the most significant byte.
    always_comb begin
        case (req_op)
            OP_SW:   beat0_wdata = req_wdata;
            OP_SB:   beat0_wdata = {24'd0, req_wdata[7:0]};
            OP_SH:   beat0_wdata = {24'd0, req_wdata[15:8]};
            default: beat0_wdata = 32'd0;
        endcase
    end

    // Main FSM. Memory and response outputs are all registered here so they
    // are stable for the whole beat/response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= 3'd0;
            signed_q       <= 1'b0;
            addr_q         <= 32'd0;
            wdata_lo_q     <= 8'd0;
            beat0_byte     <= 8'd0;
            address        <= 32'd0;
            write_data     <= 32'd0;
            Mem_Write_Read <= 2'b00;
            word_byte      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_data      <= 32'd0;
            resp_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= req_op;
                        signed_q   <= req_signed;
                        addr_q     <= req_addr;
                        wdata_lo_q <= req_wdata[7:0];
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            state          <= BEAT0;
                            address        <= req_addr;
                            write_data     <= beat0_wdata;
                            word_byte      <= (req_op[2:1] != 2'b00);
                            // Even opcodes are loads, odd opcodes are stores.
                            Mem_Write_Read <= req_op[0] ? 2'b01 : 2'b10;
                        end
                    end
                end

                BEAT0: begin
                    beat0_byte <= Read_data[7:0];
                    if (half_q) begin
                        state      <= BEAT1;
                        address    <= addr_q + 32'd1;
                        write_data <= (op_q == OP_SH) ? {24'd0, wdata_lo_q} : 32'd0;
                    end else begin
                        state          <= RESP;
                        address        <= 32'd0;
                        write_data     <= 32'd0;
                        Mem_Write_Read <= 2'b00;
                        word_byte      <= 1'b0;
                        resp_valid     <= 1'b1;
                        resp_fault     <= 1'b0;
                        case (op_q)
                            OP_LW:   resp_data <= Read_data;
                            OP_LB:   resp_data <= ext8(Read_data[7:0], signed_q);
                            default: resp_data <= 32'd0;
                        endcase
                    end
                end

                BEAT1: begin
                    state          <= RESP;
                    address        <= 32'd0;
                    write_data     <= 32'd0;
                    Mem_Write_Read <= 2'b00;
                    word_byte      <= 1'b0;
                    resp_valid     <= 1'b1;
                    resp_fault     <= 1'b0;
                    resp_data      <= (op_q == OP_LH)
                                      ? ext16({beat0_byte, Read_data[7:0]}, signed_q)
                                      : 32'd0;
                end

                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_data  <= 32'd0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//
// Bench for mem_access_unit. A byte-array memory model answers the DUT's
// memory port; a separate reference byte array predicts results. Expected
// responses and memory beats are queued when a request is driven and are
// popped when the DUT produces them.

module tb_mem_access_unit;

    localparam int MEM_BYTES = 32;

    localparam logic [2:0] OP_LW = 3'b000;
    localparam logic [2:0] OP_SW = 3'b001;
    localparam logic [2:0] OP_LB = 3'b010;
    localparam logic [2:0] OP_SB = 3'b011;
    localparam logic [2:0] OP_LH = 3'b100;
    localparam logic [2:0] OP_SH = 3'b101;

    typedef struct packed {
        logic        fault;
        logic [31:0] data;
        logic [31:0] due;
    } resp_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic        wb;
        logic [31:0] wdata;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  Mem_Write_Read;
    logic        word_byte;
    logic [31:0] Read_data;

    logic [7:0] sim_mem [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    resp_t resp_q [$];
    beat_t beat_q [$];
    resp_t mon_resp;
    beat_t mon_beat;

    int check_count = 0;
    int error_count = 0;
    int cycle = 0;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault),
        .address        (address),
        .write_data     (write_data),
        .Mem_Write_Read (Mem_Write_Read),
        .word_byte      (word_byte),
        .Read_data      (Read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    // Memory model: word at aligned address a initially holds a+4, big-endian.
    initial begin
        for (int a = 0; a < MEM_BYTES; a += 4) begin
            for (int k = 0; k < 3; k++) begin
                sim_mem[a+k] = 8'd0;
                ref_mem[a+k] = 8'd0;
            end
            sim_mem[a+3] = 8'(a + 4);
            ref_mem[a+3] = 8'(a + 4);
        end
        Read_data = 32'd0;
    end

    // Write beats commit at the posedge ending the beat; the memory ignores
    // them while reset is asserted.
    always @(posedge clk) begin
        if (!rst && Mem_Write_Read == 2'b01) begin
            if (word_byte) begin
                sim_mem[address[4:0]] = write_data[7:0];
            end else begin
                sim_mem[address[4:0]]         = write_data[31:24];
                sim_mem[address[4:0] + 5'd1]  = write_data[23:16];
                sim_mem[address[4:0] + 5'd2]  = write_data[15:8];
                sim_mem[address[4:0] + 5'd3]  = write_data[7:0];
            end
        end
    end

    // Read data settles at the mid-beat negedge.
    always @(negedge clk) begin
        if (Mem_Write_Read == 2'b10) begin
            if (word_byte)
                Read_data = {24'd0, sim_mem[address[4:0]]};
            else
                Read_data = {sim_mem[address[4:0]], sim_mem[address[4:0] + 5'd1],
                             sim_mem[address[4:0] + 5'd2], sim_mem[address[4:0] + 5'd3]};
        end
    end

    // Response and memory-port monitor.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                checkOutput("resp_spurious", 64'd1, 64'd0);
            end else begin
                mon_resp = resp_q.pop_front();
                checkOutput("resp_data", resp_data, mon_resp.data);
                checkOutput("resp_fault", resp_fault, mon_resp.fault);
                checkOutput("resp_latency", cycle, mon_resp.due);
            end
        end else begin
            checkOutput("resp_idle", {resp_fault, resp_data}, 64'd0);
        end
        if (Mem_Write_Read != 2'b00) begin
            if (beat_q.size() == 0) begin
                checkOutput("beat_spurious", Mem_Write_Read, 64'd0);
            end else begin
                mon_beat = beat_q.pop_front();
                checkOutput("beat_cmd", Mem_Write_Read, mon_beat.cmd);
                checkOutput("beat_addr", address, mon_beat.addr);
                checkOutput("beat_wb", word_byte, mon_beat.wb);
                if (mon_beat.cmd == 2'b01)
                    checkOutput("beat_wdata", write_data, mon_beat.wdata);
            end
        end else begin
            checkOutput("mem_idle", {word_byte, address, write_data}, 64'd0);
        end
    end

    function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input logic s);
        logic [31:0] r;
        r = v;
        if (bits == 8)  r = s ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
        if (bits == 16) r = s ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
        return r;
    endfunction

    // Reference prediction: pushes the expected response and memory beats,
    // and applies stores to the reference memory.
    task automatic predict(input logic [2:0] op, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] wdata, input int acc);
        int          size;
        logic [63:0] end_addr;
        bit          bad;
        int          a;
        resp_t       r;
        size = (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LH || op == OP_SH) ? 2 : 1;
        end_addr = {32'd0, addr} + 64'(size);
        bad = (op > 3'd5) || (size == 4 && addr[1:0] != 2'b00) ||
              (size == 2 && addr[0]) || (end_addr > 64'(MEM_BYTES));
        if (bad) begin
            r = '{fault: 1'b1, data: 32'd0, due: 32'(acc)};
            resp_q.push_back(r);
            return;
        end
        a = int'(addr);
        r = '{fault: 1'b0, data: 32'd0, due: 32'(acc + 1)};
        case (op)
            OP_LW: begin
                r.data = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                beat_q.push_back('{cmd: 2'b10, addr: addr, wb: 1'b0, wdata: 32'd0});
            end
            OP_SW: begin
                {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]} = wdata;
                beat_q.push_back('{cmd: 2'b01, addr: addr, wb: 1'b0, wdata: wdata});
            end
            OP_LB: begin
                r.data = ext({24'd0, ref_mem[a]}, 8, sgn);
                beat_q.push_back('{cmd: 2'b10, addr: addr, wb: 1'b1, wdata: 32'd0});
            end
            OP_SB: begin
                ref_mem[a] = wdata[7:0];
                beat_q.push_back('{cmd: 2'b01, addr: addr, wb: 1'b1, wdata: {24'd0, wdata[7:0]}});
            end
            OP_LH: begin
                r.data = ext({16'd0, ref_mem[a], ref_mem[a+1]}, 16, sgn);
                r.due  = 32'(acc + 2);
                beat_q.push_back('{cmd: 2'b10, addr: addr, wb: 1'b1, wdata: 32'd0});
                beat_q.push_back('{cmd: 2'b10, addr: addr + 32'd1, wb: 1'b1, wdata: 32'd0});
            end
            default: begin
                ref_mem[a]   = wdata[15:8];
                ref_mem[a+1] = wdata[7:0];
                r.due = 32'(acc + 2);
                beat_q.push_back('{cmd: 2'b01, addr: addr, wb: 1'b1, wdata: {24'd0, wdata[15:8]}});
                beat_q.push_back('{cmd: 2'b01, addr: addr + 32'd1, wb: 1'b1, wdata: {24'd0, wdata[7:0]}});
            end
        endcase
        resp_q.push_back(r);
    endtask

    // Drives one request and returns the cycle number of the accepting edge.
    // With hold set, req_valid stays high after acceptance.
    task automatic applyStimulus(input logic [2:0] op, input logic sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold, output int acc);
        int waited;
        @(negedge clk);
        req_op     = op;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle + 1;
        predict(op, sgn, addr, wdata, acc);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && resp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int prev;
        logic [7:0] save17;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", req_ready, 64'd0);
        checkOutput("reset_cmd", Mem_Write_Read, 64'd0);
        checkOutput("reset_resp", resp_valid, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", req_ready, 64'd1);

        applyStimulus(OP_LW, 1'b0, 32'd4, 32'd0, 1'b0, acc);
        drain();

        applyStimulus(OP_SW, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0, acc);
        applyStimulus(OP_LB, 1'b1, 32'd8, 32'd0, 1'b0, acc);
        applyStimulus(OP_LB, 1'b0, 32'd9, 32'd0, 1'b0, acc);
        applyStimulus(OP_LW, 1'b0, 32'd8, 32'd0, 1'b0, acc);

        applyStimulus(OP_SH, 1'b0, 32'd12, 32'h0000A5C3, 1'b0, acc);
        applyStimulus(OP_LH, 1'b1, 32'd12, 32'd0, 1'b0, acc);
        applyStimulus(OP_LH, 1'b0, 32'd12, 32'd0, 1'b0, acc);
        applyStimulus(OP_LW, 1'b0, 32'd12, 32'd0, 1'b0, acc);

        applyStimulus(OP_SB, 1'b0, 32'd20, 32'hFFFFFF7F, 1'b0, acc);
        applyStimulus(OP_LB, 1'b1, 32'd20, 32'd0, 1'b0, acc);
        drain();

        // Faulting requests back to back: one accepted every 2 cycles.
        applyStimulus(OP_LW, 1'b0, 32'd2, 32'd0, 1'b1, prev);
        applyStimulus(OP_LW, 1'b0, 32'd32, 32'd0, 1'b1, acc);
        checkOutput("fault_gap", 64'(acc - prev), 64'd2);
        prev = acc;
        applyStimulus(OP_LH, 1'b0, 32'd31, 32'd0, 1'b1, acc);
        checkOutput("fault_gap", 64'(acc - prev), 64'd2);
        prev = acc;
        applyStimulus(3'b110, 1'b0, 32'd0, 32'd0, 1'b0, acc);
        checkOutput("fault_gap", 64'(acc - prev), 64'd2);

        applyStimulus(OP_LW, 1'b0, 32'd28, 32'd0, 1'b0, acc);
        drain();

        // Reset during BEAT1 of a halfword store: only the first byte lands.
        save17 = ref_mem[17];
        applyStimulus(OP_SH, 1'b0, 32'd16, 32'h00001234, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_cmd", Mem_Write_Read, 64'd0);
        checkOutput("rst_addr", address, 64'd0);
        checkOutput("rst_resp", resp_valid, 64'd0);
        checkOutput("rst_ready", req_ready, 64'd0);
        rst = 1'b0;
        resp_q.delete();
        ref_mem[17] = save17;
        @(negedge clk);
        checkOutput("ready_after_rst", req_ready, 64'd1);
        applyStimulus(OP_LB, 1'b0, 32'd16, 32'd0, 1'b0, acc);
        applyStimulus(OP_LB, 1'b0, 32'd17, 32'd0, 1'b0, acc);
        drain();

        // Back-to-back loads with req_valid held high.
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(OP_LW, 1'b0, 32'(i * 4), 32'd0, (i < 7), acc);
            if (i > 0) checkOutput("b2b_gap", 64'(acc - prev), 64'd3);
            prev = acc;
        end
        drain();

        checkOutput("resp_q_empty", 64'(resp_q.size()), 64'd0);
        checkOutput("beat_q_empty", 64'(beat_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the MEM stage. It accepts one memory request per handshake from the pipeline and drives the data memory port: `address`, `write_data`, `Mem_Write_Read` and `word_byte`. Read data is sampled back from `Read_data`. The block adds alignment and range checking, halfword support (built from two byte beats), and sign/zero extension of loads, then returns a single response pulse to the pipeline.

## Interface
- `MEM_BYTES`, default 32: data memory size in bytes; used for the range check.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_op` in 3: operation code.
  - 000 LW, 001 SW, 010 LB, 011 SB, 100 LH, 101 SH.
  - 110 and 111 are illegal.
- `req_signed` in 1: sign-extend LB/LH results; ignored for other ops.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_data` out 32: load result; 0 for stores and faults.
- `resp_fault` out 1: request rejected; qualified by `resp_valid`.
- `address` out 32: memory byte address.
- `write_data` out 32: memory store data.
- `Mem_Write_Read` out 2: memory command; 10 read, 01 write, 00 idle.
- `word_byte` out 1: 0 word access, 1 byte access.
- `Read_data` in 32: memory read data.
  - The memory updates it on negedge of a read cycle.
  - Byte reads return the byte in [7:0].

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- `req_ready` = (state==IDLE) && !rst. Accept on posedge when `req_valid && req_ready`; latch op, signed, addr, wdata.
- Fault check at accept. Range uses 33-bit arithmetic, size = 4/2/1 for word/half/byte. A request faults if any of:
  - illegal op;
  - LW/SW with addr[1:0]!=0;
  - LH/SH with addr[0]!=0;
  - addr + size > MEM_BYTES.
- Transitions:
  - IDLE → RESP on a faulting request; no memory beat is issued.
  - IDLE → BEAT0 on a good request.
  - BEAT0 → BEAT1 for LH/SH.
  - BEAT0 → RESP for all other ops.
  - BEAT1 → RESP.
  - RESP → IDLE.
- Memory outputs are registered and valid for the whole BEAT cycle:
  - LW/SW: `word_byte`=0, `address`=addr.
  - LB/SB: `word_byte`=1, `address`=addr.
  - LH/SH, BEAT0: `word_byte`=1, `address`=addr.
  - LH/SH, BEAT1: `word_byte`=1, `address`=addr+1.
  - Loads drive `Mem_Write_Read`=10; stores drive 01.
- Store data:
  - SW drives `write_data`=wdata.
  - SB drives {24'b0, wdata[7:0]}.
  - SH drives {24'b0, wdata[15:8]} in BEAT0 and {24'b0, wdata[7:0]} in BEAT1.
  - Big-endian: the lower address holds the MSB.
- Load data: `Read_data` is captured at the posedge ending each read beat.
  - LW result = Read_data.
  - LB result = ext(Read_data[7:0]).
  - LH result = ext({beat0[7:0], beat1[7:0]}).
  - ext sign-extends when `req_signed`=1, otherwise zero-extends.
- Outside BEAT states, memory outputs are: `Mem_Write_Read`=00, `address`=0, `write_data`=0, `word_byte`=0.
- RESP drives `resp_valid`=1 for exactly one cycle with `resp_data` and `resp_fault`. Both are 0 in all other cycles.
- No response backpressure; the pipeline must consume `resp_valid` when it is asserted.

## Timing
- Accept at edge E. BEAT0 runs E..E+1.
- Single-beat ops: `resp_valid` high E+1..E+2, back in IDLE at E+2.
- Halfword ops: `resp_valid` high E+2..E+3.
- Fault: `resp_valid` high E..E+1.
- Throughput:
  - one request per 3 cycles for single-beat ops;
  - one per 4 cycles for halfword ops;
  - one per 2 cycles for faults.
- Memory timing:
  - The memory samples write beats at the posedge ending the beat.
  - Read data settles at mid-beat negedge; it is sampled at the posedge ending the beat.
- Reset values: state IDLE; all outputs 0; captured data cleared.
- Reset mid-operation abandons the request.
  - No `resp_valid` is produced.
  - Memory outputs return to idle at the next edge.
  - A write beat already sampled by the memory stays committed, so SH may leave only its first byte written.
- `req_valid` during non-IDLE states is ignored; the request is not lost if the source holds it.

## Test plan
- After reset, with default memory contents, LW addr 4: `Mem_Write_Read`=10 for one cycle, `address`=4 → resp 0x00000008 two cycles after accept, `resp_fault`=0.
- SW addr 8 wdata 0xDEADBEEF, then:
  - LB signed addr 8 → 0xFFFFFFDE;
  - LB unsigned addr 9 → 0x000000AD;
  - LW addr 8 → 0xDEADBEEF.
- SH addr 12 wdata 0x0000A5C3 issues two 01 beats at `address` 12 and 13, with `write_data` 0xA5 then 0xC3. Then:
  - LH signed addr 12 → 0xFFFFA5C3;
  - LW addr 12 → 0xA5C30010.
- Each of the following → `resp_fault`=1, `resp_data`=0, response one cycle after accept, `Mem_Write_Read` stays 00:
  - LW addr 2;
  - LW addr 32;
  - LH addr 31;
  - op 110.
- LW addr 28 (the boundary case) → 0x00000020, no fault.
- Assert `rst` during BEAT1 of SH addr 16 wdata 0x1234:
  - no `resp_valid`; outputs 0 next cycle;
  - `req_ready`=1 after release;
  - LB addr 16 → 0x12 and LB addr 17 → 0x00.
- Hold `req_valid` high with back-to-back LWs: `req_ready` pulses every third cycle, and each response matches the word at its address.
